// File: rtl/count_timestamp_fifo.sv
// Captures the free-running count on each rising edge of event_in and buffers the
// timestamps in a small FIFO with a valid/ready output and dropped-event accounting.
module count_timestamp_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 3,
  parameter int DROP_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      count,
  input  logic                  event_in,
  input  logic                  clear_overflow,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic [DROP_W-1:0]     drop_count
);

  localparam int                DEPTH     = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
  localparam logic [DROP_W-1:0] DROP_ONE  = DROP_W'(1);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [DEPTH_LOG2:0]   level_reg;
  logic                  event_q_reg;
  logic                  overflow_reg;
  logic [DROP_W-1:0]     drop_count_reg;

  logic push_req;
  logic pop;
  logic full;
  logic push;
  logic drop;

  assign push_req = event_in & ~event_q_reg;
  assign full     = (level_reg == LVL_FULL);
  assign pop      = out_valid & out_ready;
  // A pop frees the head slot on the same edge, so a full FIFO can still accept.
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  // Storage carries no reset; out_data masking hides stale contents.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk) begin
        if (!rst && push && (wr_ptr_reg == DEPTH_LOG2'(gi))) begin
          mem[gi] <= count;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      event_q_reg    <= 1'b0;
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
    end else begin
      event_q_reg <= event_in;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;

      case ({push, pop})
        2'b10:   level_reg <= level_reg + LVL_ONE;
        2'b01:   level_reg <= level_reg - LVL_ONE;
        default: level_reg <= level_reg;
      endcase

      // A drop coinciding with a clear is counted after the clear.
      if (clear_overflow) begin
        overflow_reg   <= drop;
        drop_count_reg <= drop ? DROP_ONE : '0;
      end else if (drop) begin
        overflow_reg <= 1'b1;
        if (!(&drop_count_reg)) drop_count_reg <= drop_count_reg + DROP_ONE;
      end
    end
  end

  assign out_valid  = (level_reg != '0);
  assign out_data   = out_valid ? mem[rd_ptr_reg] : '0;
  assign level      = level_reg;
  assign overflow   = overflow_reg;
  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_count_timestamp_fifo.sv
// Directed bench for count_timestamp_fifo: a queue-based reference model checked every
// cycle, plus hand-computed literal checks at the scenario boundaries.
module tb_count_timestamp_fifo;

  localparam int DW = 8;  // narrow drop counter so saturation is reachable quickly

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   count;
  logic          event_in;
  logic          clear_overflow;
  logic [31:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    level;
  logic          overflow;
  logic [DW-1:0] drop_count;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] mq[$];
  logic        m_ovf = 1'b0;
  int          m_drops = 0;
  logic        m_prev_ev = 1'b0;
  logic        m_live = 1'b0;

  count_timestamp_fifo #(.WIDTH(32), .DEPTH_LOG2(3), .DROP_W(DW)) dut (
    .clk(clk), .rst(rst), .count(count), .event_in(event_in),
    .clear_overflow(clear_overflow), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .level(level), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (m_live) begin
      chk("valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
      chk("data", out_data, (mq.size() != 0) ? mq[0] : 32'h0);
      chk("level", {28'b0, level}, 32'(mq.size()));
      chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
      chk("drop_count", {24'b0, drop_count}, 32'(m_drops));
    end
  end

  task automatic cyc(input logic ev, input logic [31:0] c, input logic rdy,
                     input logic clr, input logic r);
    logic preq, pop, full, drop;
    event_in = ev; count = c; out_ready = rdy; clear_overflow = clr; rst = r;
    @(posedge clk);
    if (r) begin
      mq.delete(); m_ovf = 1'b0; m_drops = 0; m_prev_ev = 1'b0; m_live = 1'b1;
    end else begin
      preq = ev && !m_prev_ev;
      full = (mq.size() == 8);
      pop  = (mq.size() != 0) && rdy;
      drop = preq && full && !pop;
      if (pop) void'(mq.pop_front());
      if (preq && !drop) mq.push_back(c);
      if (clr) begin
        m_ovf = drop; m_drops = drop ? 1 : 0;
      end else if (drop) begin
        m_ovf = 1'b1;
        if (m_drops < (1 << DW) - 1) m_drops++;
      end
      m_prev_ev = ev;
    end
    #1;
  endtask

  task automatic edge_at(input logic [31:0] c, input logic rdy);
    cyc(1'b1, c, rdy, 1'b0, 1'b0);
    cyc(1'b0, c, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop_one();
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    #4;
    chk("reset_level", {28'b0, level}, 32'd0);
    chk("reset_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_data", out_data, 32'd0);
    $display("reset done");

    // 1: held-high event gives one capture
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'd100, 1'b0, 1'b0, 1'b0);
    chk("t1_level", {28'b0, level}, 32'd1);
    chk("t1_data", out_data, 32'd100);
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    $display("t1 held event -> one entry");

    // 2: fill, overflow, drain in order
    for (int i = 1; i <= 8; i++) edge_at(32'(10 * i), 1'b0);
    chk("t2_full_level", {28'b0, level}, 32'd8);
    chk("t2_full_ovf", {31'b0, overflow}, 32'd0);
    edge_at(32'd90, 1'b0);
    chk("t2_drop_level", {28'b0, level}, 32'd8);
    chk("t2_drop_ovf", {31'b0, overflow}, 32'd1);
    chk("t2_drop_cnt", {24'b0, drop_count}, 32'd1);
    for (int i = 1; i <= 8; i++) begin
      chk("t2_drain", out_data, 32'(10 * i));
      pop_one();
    end
    chk("t2_empty_valid", {31'b0, out_valid}, 32'd0);
    chk("t2_empty_data", out_data, 32'd0);
    cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    $display("t2 fill/overflow/drain");

    // 3: full plus simultaneous pop and push
    for (int i = 1; i <= 8; i++) edge_at(32'(100 + 10 * i), 1'b0);
    edge_at(32'd200, 1'b1);
    chk("t3_level", {28'b0, level}, 32'd8);
    chk("t3_ovf", {31'b0, overflow}, 32'd0);
    for (int i = 2; i <= 8; i++) begin
      chk("t3_drain", out_data, 32'(100 + 10 * i));
      pop_one();
    end
    chk("t3_last", out_data, 32'd200);
    pop_one();
    $display("t3 full push+pop");

    // 4: push+pop at empty, and at level 3
    edge_at(32'd300, 1'b1);
    chk("t4_level1", {28'b0, level}, 32'd1);
    edge_at(32'd310, 1'b0);
    edge_at(32'd320, 1'b0);
    edge_at(32'd330, 1'b1);
    chk("t4_level3", {28'b0, level}, 32'd3);
    chk("t4_head", out_data, 32'd310);
    for (int i = 0; i < 3; i++) pop_one();
    $display("t4 push+pop at level 0 and 3");

    // 5: drop saturation and clear behaviour
    for (int i = 1; i <= 8; i++) edge_at(32'(1000 + i), 1'b0);
    for (int i = 0; i < 260; i++) edge_at(32'(2000 + i), 1'b0);
    chk("t5_sat", {24'b0, drop_count}, 32'h0000_00FF);
    cyc(1'b1, 32'd5000, 1'b0, 1'b1, 1'b0);
    chk("t5_clr_drop_ovf", {31'b0, overflow}, 32'd1);
    chk("t5_clr_drop_cnt", {24'b0, drop_count}, 32'd1);
    cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("t5_clr_ovf", {31'b0, overflow}, 32'd0);
    chk("t5_clr_cnt", {24'b0, drop_count}, 32'd0);
    $display("t5 saturation and clear");

    // 6: reset mid-operation, event high across reset
    for (int i = 0; i < 3; i++) pop_one();
    chk("t6_level5", {28'b0, level}, 32'd5);
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    chk("t6_rst_level", {28'b0, level}, 32'd0);
    chk("t6_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("t6_rst_ovf", {31'b0, overflow}, 32'd0);
    cyc(1'b1, 32'd500, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'd600, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'd700, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'd800, 1'b0, 1'b0, 1'b0);
    chk("t6_cap_level", {28'b0, level}, 32'd1);
    chk("t6_cap_data", out_data, 32'd600);
    $display("t6 reset mid-operation");

    #10;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
